mem_write_checker: RTL and testbench

//  Synthesizable, parametrised successor to the bench-only "write 7 to address 100" pass/fail check.

---
 rtl/mem_write_checker.sv | 156 +++++++++++++++
 tb/tb_mem_write_checker.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mem_write_checker.sv
// Snoops the data-memory write bus and checks it against an ordered table of expected writes,
// skipping a scratch window, with optional timeout. Optional WrCount port: define MWC_WRCOUNT_EN.
module mem_write_checker #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int N_EXP      = 4,
  parameter int IDX_W      = 2,
  parameter int SCRATCH_LO = 96,
  parameter int SCRATCH_HI = 96,
  parameter int TIMEOUT    = 1000,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Start,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] DataAdr,
  input  logic [DATA_W-1:0] WriteData,
  input  logic              ExpWe,
  input  logic [IDX_W-1:0]  ExpIdx,
  input  logic [ADDR_W-1:0] ExpAdr,
  input  logic [DATA_W-1:0] ExpData,
  input  logic [IDX_W:0]    ExpCount,
  output logic              Done,
  output logic              Pass,
  output logic              Fail,
  output logic              Timeout,
  output logic [ADDR_W-1:0] FailAdr,
  output logic [DATA_W-1:0] FailData,
`ifdef MWC_WRCOUNT_EN
  output logic [CNT_W-1:0]  WrCount,
`endif
  output logic [IDX_W:0]    MatchIdx
);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_PASS, S_FAIL, S_TOUT} state_t;

  localparam int              CW      = IDX_W + 1;
  localparam logic [IDX_W:0]  N_EXP_C = CW'(N_EXP);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
  localparam bit              SCR_EN  = (SCRATCH_LO <= SCRATCH_HI);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   tab_adr_q [N_EXP];
  logic [DATA_W-1:0]   tab_dat_q [N_EXP];
  logic [IDX_W:0]      count_q, count_d;
  logic [IDX_W:0]      ptr_q, ptr_d;
  logic [CNT_W-1:0]    timer_q, timer_d;
  logic [ADDR_W-1:0]   fail_adr_q, fail_adr_d;
  logic [DATA_W-1:0]   fail_dat_q, fail_dat_d;

  logic                tab_we;
  logic                arm;
  logic                scratch_hit;
  logic                entry_match;
  logic [IDX_W:0]      ptr_inc;
  logic [IDX_W:0]      start_count;

  assign scratch_hit = SCR_EN && (DataAdr >= ADDR_W'(SCRATCH_LO)) && (DataAdr <= ADDR_W'(SCRATCH_HI));
  assign entry_match = (DataAdr == tab_adr_q[ptr_q[IDX_W-1:0]]) &&
                       (WriteData == tab_dat_q[ptr_q[IDX_W-1:0]]);
  assign ptr_inc     = ptr_q + 1'b1;
  assign start_count = (ExpCount > N_EXP_C) ? N_EXP_C : ExpCount;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    ptr_d      = ptr_q;
    timer_d    = timer_q;
    fail_adr_d = fail_adr_q;
    fail_dat_d = fail_dat_q;
    tab_we     = 1'b0;
    arm        = 1'b0;
    case (state_q)
      S_IDLE: begin
        tab_we = ExpWe;
        arm    = Start;
      end
      S_RUN: begin
        timer_d = (timer_q == '1) ? timer_q : timer_q + 1'b1;
        if (MemWrite && !scratch_hit) begin
          if (entry_match) begin
            ptr_d = ptr_inc;
            if (ptr_inc == count_q) state_d = S_PASS;
          end else begin
            state_d    = S_FAIL;
            fail_adr_d = DataAdr;
            fail_dat_d = WriteData;
          end
        end
        // Timeout only wins when the write bus made no decision this cycle.
        if (TIMEOUT != 0 && state_d == S_RUN && timer_q == TO_LAST) state_d = S_TOUT;
      end
      default: arm = Start;
    endcase
    if (arm) begin
      count_d    = start_count;
      ptr_d      = '0;
      timer_d    = '0;
      fail_adr_d = '0;
      fail_dat_d = '0;
      state_d    = (start_count == '0) ? S_PASS : S_RUN;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      ptr_q      <= '0;
      timer_q    <= '0;
      fail_adr_q <= '0;
      fail_dat_q <= '0;
      for (int i = 0; i < N_EXP; i++) begin
        tab_adr_q[i] <= '0;
        tab_dat_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      ptr_q      <= ptr_d;
      timer_q    <= timer_d;
      fail_adr_q <= fail_adr_d;
      fail_dat_q <= fail_dat_d;
      if (tab_we) begin
        tab_adr_q[ExpIdx] <= ExpAdr;
        tab_dat_q[ExpIdx] <= ExpData;
      end
    end
  end

`ifdef MWC_WRCOUNT_EN
  logic [CNT_W-1:0] wr_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_cnt_q <= '0;
    end else if (arm) begin
      wr_cnt_q <= '0;
    end else if (state_q == S_RUN && MemWrite && wr_cnt_q != '1) begin
      wr_cnt_q <= wr_cnt_q + 1'b1;
    end
  end

  assign WrCount = wr_cnt_q;
`endif

  assign Pass     = (state_q == S_PASS);
  assign Fail     = (state_q == S_FAIL);
  assign Timeout  = (state_q == S_TOUT);
  assign Done     = Pass | Fail | Timeout;
  assign FailAdr  = fail_adr_q;
  assign FailData = fail_dat_q;
  assign MatchIdx = ptr_q;

endmodule

// File: tb/tb_mem_write_checker.sv
// Directed bench for mem_write_checker: ordered matching, scratch skip, fail capture, timeout, reset.
module tb_mem_write_checker;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int IDX_W  = 2;
  localparam int CNT_W  = 16;
  localparam int TO     = 20;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              Start = 1'b0;
  logic              MemWrite = 1'b0;
  logic [ADDR_W-1:0] DataAdr = '0;
  logic [DATA_W-1:0] WriteData = '0;
  logic              ExpWe = 1'b0;
  logic [IDX_W-1:0]  ExpIdx = '0;
  logic [ADDR_W-1:0] ExpAdr = '0;
  logic [DATA_W-1:0] ExpData = '0;
  logic [IDX_W:0]    ExpCount = '0;
  logic              Done, Pass, Fail, Timeout;
  logic [ADDR_W-1:0] FailAdr;
  logic [DATA_W-1:0] FailData;
  logic [IDX_W:0]    MatchIdx;
`ifdef MWC_WRCOUNT_EN
  logic [CNT_W-1:0]  WrCount;
`endif

  int n_cmp = 0;
  int n_fail = 0;

  mem_write_checker #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .N_EXP(4), .IDX_W(IDX_W),
    .SCRATCH_LO(96), .SCRATCH_HI(96), .TIMEOUT(TO), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .Start(Start), .MemWrite(MemWrite),
    .DataAdr(DataAdr), .WriteData(WriteData), .ExpWe(ExpWe), .ExpIdx(ExpIdx),
    .ExpAdr(ExpAdr), .ExpData(ExpData), .ExpCount(ExpCount),
    .Done(Done), .Pass(Pass), .Fail(Fail), .Timeout(Timeout),
    .FailAdr(FailAdr), .FailData(FailData),
`ifdef MWC_WRCOUNT_EN
    .WrCount(WrCount),
`endif
    .MatchIdx(MatchIdx)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    MemWrite = 1'b1; DataAdr = a; WriteData = d;
    tick();
    MemWrite = 1'b0;
  endtask

  task automatic tab(input logic [IDX_W-1:0] i, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    ExpWe = 1'b1; ExpIdx = i; ExpAdr = a; ExpData = d;
    tick();
    ExpWe = 1'b0;
  endtask

  task automatic arm(input logic [IDX_W:0] cnt);
    ExpCount = cnt; Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  initial begin
    tick(); tick();
    chk("rst_done", Done, 0);
    chk("rst_pass", Pass, 0);
    chk("rst_fail", Fail, 0);
    chk("rst_tout", Timeout, 0);
    chk("rst_match", MatchIdx, 0);
    chk("rst_fadr", FailAdr, 0);
    reset = 1'b0;
    tick();

    // 1: scratch write ignored, then matching write passes
    tab(0, 100, 7);
    arm(1);
    chk("t1_run_done", Done, 0);
    wr(96, 5);
    chk("t1_scratch_done", Done, 0);
    chk("t1_scratch_fail", Fail, 0);
    wr(100, 7);
    chk("t1_pass", Pass, 1);
    chk("t1_done", Done, 1);
    chk("t1_match", MatchIdx, 1);
    chk("t1_fail", Fail, 0);

    // 2: wrong address fails and is captured
    arm(1);
    chk("t2_rearm_pass", Pass, 0);
    chk("t2_rearm_match", MatchIdx, 0);
    wr(104, 7);
    chk("t2_fail", Fail, 1);
    chk("t2_fadr", FailAdr, 104);
    chk("t2_fdat", FailData, 7);
    chk("t2_pass", Pass, 0);

    // 3: wrong data fails; later correct write leaves verdict alone
    arm(1);
    chk("t3_rearm_fadr", FailAdr, 0);
    wr(100, 6);
    chk("t3_fail", Fail, 1);
    chk("t3_fdat", FailData, 6);
    wr(100, 7);
    chk("t3_fail_hold", Fail, 1);
    chk("t3_pass_hold", Pass, 0);
    chk("t3_fdat_hold", FailData, 6);

    // 4: timeout exactly TO cycles after the Start edge
    arm(1);
    for (int i = 0; i < TO - 1; i++) tick();
    chk("t4_before_tout", Timeout, 0);
    chk("t4_before_done", Done, 0);
    tick();
    chk("t4_tout", Timeout, 1);
    chk("t4_done", Done, 1);
    arm(0);
    chk("t4_cnt0_pass", Pass, 1);
    chk("t4_cnt0_tout", Timeout, 0);

    // 6: final match on the timeout cycle wins over timeout
    arm(1);
    MemWrite = 1'b1; DataAdr = 96; WriteData = 3;
    for (int i = 0; i < TO - 1; i++) tick();
    chk("t6_scratch_done", Done, 0);
    DataAdr = 100; WriteData = 7;
    tick();
    MemWrite = 1'b0;
    chk("t6_pass", Pass, 1);
    chk("t6_tout", Timeout, 0);
`ifdef MWC_WRCOUNT_EN
    chk("t6_wrcount", WrCount, TO);
`endif

    // Table writes outside IDLE are ignored
    tab(0, 200, 1);
    arm(1);
    wr(100, 7);
    chk("exp_we_ignored", Pass, 1);

    // 5: reset mid-run clears everything, including the table
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    tab(0, 100, 7);
    tab(1, 104, 9);
    arm(2);
    wr(100, 7);
    chk("t5_match1", MatchIdx, 1);
    chk("t5_run_done", Done, 0);
    reset = 1'b1;
    #1;
    chk("t5_rst_match", MatchIdx, 0);
    chk("t5_rst_done", Done, 0);
    tick();
    reset = 1'b0;
    tick();
    arm(2);
    wr(0, 0);
    chk("t5_clr_match1", MatchIdx, 1);
    wr(0, 0);
    chk("t5_clr_pass", Pass, 1);
    chk("t5_clr_match2", MatchIdx, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
